// File: rtl/demux8_1to16_reg.sv
// Registered 1-to-16 byte demultiplexer with valid/ready input, addressed or
// sequential targeting, and a frame-complete handshake.
module demux8_1to16_reg #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din,
    input  logic [SEL_W-1:0]  select,
    input  logic              mode,
    input  logic              clear,
    input  logic              frame_ack,
    output logic [DATA_W-1:0] o0,
    output logic [DATA_W-1:0] o1,
    output logic [DATA_W-1:0] o2,
    output logic [DATA_W-1:0] o3,
    output logic [DATA_W-1:0] o4,
    output logic [DATA_W-1:0] o5,
    output logic [DATA_W-1:0] o6,
    output logic [DATA_W-1:0] o7,
    output logic [DATA_W-1:0] o8,
    output logic [DATA_W-1:0] o9,
    output logic [DATA_W-1:0] o10,
    output logic [DATA_W-1:0] o11,
    output logic [DATA_W-1:0] o12,
    output logic [DATA_W-1:0] o13,
    output logic [DATA_W-1:0] o14,
    output logic [DATA_W-1:0] o15,
    output logic [15:0]       o_valid,
    output logic [SEL_W-1:0]  ptr,
    output logic              frame_done
);

    localparam int unsigned NUM_OUT = 16;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NUM_OUT-1:0][DATA_W-1:0] regs;
    logic [SEL_W-1:0]               target;
    logic [NUM_OUT-1:0]             target_hot;
    logic                           accept;
    logic                           completes;

    // Clear drops any simultaneous write, so it is folded into the accept term.
    assign accept     = in_valid && (state_q == FILL) && !clear;
    assign target     = mode ? ptr : select;
    assign target_hot = NUM_OUT'(1) << target;
    assign completes  = (&(o_valid | target_hot)) && !o_valid[target];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (accept && completes) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (frame_ack) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        if (clear) begin
            state_d = FILL;
        end
    end

    // Data, valid flags, pointer and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs       <= '0;
            o_valid    <= '0;
            ptr        <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            regs       <= '0;
            o_valid    <= '0;
            ptr        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && completes;
            if (accept) begin
                regs[target] <= din;
                o_valid      <= o_valid | target_hot;
                if (mode) begin
                    ptr <= ptr + SEL_W'(1);
                end
            end else if ((state_q == DONE) && frame_ack) begin
                // Re-arm keeps the data so the consumer can still read it.
                o_valid <= '0;
                ptr     <= '0;
            end
        end
    end

    assign o0  = regs[0];
    assign o1  = regs[1];
    assign o2  = regs[2];
    assign o3  = regs[3];
    assign o4  = regs[4];
    assign o5  = regs[5];
    assign o6  = regs[6];
    assign o7  = regs[7];
    assign o8  = regs[8];
    assign o9  = regs[9];
    assign o10 = regs[10];
    assign o11 = regs[11];
    assign o12 = regs[12];
    assign o13 = regs[13];
    assign o14 = regs[14];
    assign o15 = regs[15];

endmodule

// File: tb/tb_demux8_1to16_reg.sv
// Directed bench for demux8_1to16_reg: sequential/addressed fills, DONE hold,
// re-arm, clear priority and asynchronous reset.
module tb_demux8_1to16_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  din;
    logic [3:0]  select;
    logic        mode;
    logic        clear;
    logic        frame_ack;
    logic [7:0]  o [16];
    logic [15:0] o_valid;
    logic [3:0]  ptr;
    logic        frame_done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0] tbl [16];

    demux8_1to16_reg #(.DATA_W(8), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .select(select), .mode(mode), .clear(clear),
        .frame_ack(frame_ack),
        .o0(o[0]), .o1(o[1]), .o2(o[2]), .o3(o[3]),
        .o4(o[4]), .o5(o[5]), .o6(o[6]), .o7(o[7]),
        .o8(o[8]), .o9(o[9]), .o10(o[10]), .o11(o[11]),
        .o12(o[12]), .o13(o[13]), .o14(o[14]), .o15(o[15]),
        .o_valid(o_valid), .ptr(ptr), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic m, input logic [3:0] s, input logic [7:0] d);
        in_valid = 1'b1;
        mode     = m;
        select   = s;
        din      = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        tbl = '{8'h00, 8'h81, 8'h02, 8'h83, 8'h07, 8'hC1, 8'hE2, 8'hAB,
                8'h60, 8'hE1, 8'h82, 8'hBF, 8'h00, 8'hA1, 8'h72, 8'h93};
        rst_n = 1'b0; in_valid = 1'b0; din = '0; select = '0; mode = 1'b0;
        clear = 1'b0; frame_ack = 1'b0;
        #12;
        check("rst_o_valid", 32'(o_valid), 32'h0);
        check("rst_ptr", 32'(ptr), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_o7", 32'(o[7]), 32'h0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // 1: sequential fill of a full frame
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("seq_no_early_done", 32'(frame_done), 32'h0);
            wr(1'b1, 4'd0, tbl[i]);
        end
        check("seq_frame_done", 32'(frame_done), 32'h1);
        check("seq_in_ready", 32'(in_ready), 32'h0);
        check("seq_ptr_wrap", 32'(ptr), 32'h0);
        check("seq_o_valid", 32'(o_valid), 32'hFFFF);
        for (int i = 0; i < 16; i++) check($sformatf("seq_o%0d", i), 32'(o[i]), 32'(tbl[i]));

        // 3: DONE ignores writes, then frame_ack re-arms keeping data
        in_valid = 1'b1; mode = 1'b1; din = 8'h55;
        step();
        check("done_pulse_end", 32'(frame_done), 32'h0);
        step();
        in_valid = 1'b0;
        check("done_o0_held", 32'(o[0]), 32'h00);
        check("done_o13_held", 32'(o[13]), 32'hA1);
        check("done_valid_held", 32'(o_valid), 32'hFFFF);
        check("done_ready_low", 32'(in_ready), 32'h0);
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        check("ack_in_ready", 32'(in_ready), 32'h1);
        check("ack_o_valid", 32'(o_valid), 32'h0);
        check("ack_ptr", 32'(ptr), 32'h0);
        check("ack_o1_kept", 32'(o[1]), 32'h81);

        // 2: addressed writes, including an overwrite
        clear = 1'b1;
        step();
        clear = 1'b0;
        wr(1'b0, 4'd2, 8'h02);
        wr(1'b0, 4'd15, 8'h93);
        wr(1'b0, 4'd2, 8'hFF);
        check("addr_o2", 32'(o[2]), 32'hFF);
        check("addr_o15", 32'(o[15]), 32'h93);
        check("addr_o_valid", 32'(o_valid), 32'h8004);
        check("addr_no_done", 32'(frame_done), 32'h0);
        check("addr_ptr", 32'(ptr), 32'h0);
        check("addr_o0", 32'(o[0]), 32'h0);
        check("addr_o14", 32'(o[14]), 32'h0);

        // 4: clear beats a simultaneous write
        for (int i = 0; i < 5; i++) wr(1'b1, 4'd0, 8'(8'h10 + i));
        check("pre_clr_ptr", 32'(ptr), 32'h5);
        check("pre_clr_o4", 32'(o[4]), 32'h14);
        clear = 1'b1; in_valid = 1'b1; mode = 1'b1; din = 8'hAA;
        step();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_o_valid", 32'(o_valid), 32'h0);
        check("clr_ptr", 32'(ptr), 32'h0);
        for (int i = 0; i < 16; i++) check($sformatf("clr_o%0d", i), 32'(o[i]), 32'h0);

        // 5: asynchronous reset mid-frame
        for (int i = 0; i < 9; i++) wr(1'b1, 4'd0, 8'(8'h20 + i));
        check("pre_rst_ptr", 32'(ptr), 32'h9);
        #2 rst_n = 1'b0;
        #1;
        check("arst_o_valid", 32'(o_valid), 32'h0);
        check("arst_ptr", 32'(ptr), 32'h0);
        check("arst_o8", 32'(o[8]), 32'h0);
        #1 rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) wr(1'b1, 4'd0, 8'(i * 17));
        check("refill_done", 32'(frame_done), 32'h1);
        check("refill_o_valid", 32'(o_valid), 32'hFFFF);
        check("refill_o9", 32'(o[9]), 32'h99);

        // 6: ack during the frame_done cycle gives a one-cycle DONE
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        check("fast_ack_ready", 32'(in_ready), 32'h1);
        check("fast_ack_valid", 32'(o_valid), 32'h0);
        check("fast_ack_done", 32'(frame_done), 32'h0);
        wr(1'b1, 4'd7, 8'h5A);
        check("fast_ack_o0", 32'(o[0]), 32'h5A);
        check("fast_ack_o1_kept", 32'(o[1]), 32'h11);
        check("fast_ack_ptr", 32'(ptr), 32'h1);
        check("fast_ack_valid2", 32'(o_valid), 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
